// File: rtl/neighbor_aggregator_if.sv
// Stream bundle for the neighbour aggregator: one input feature stream and
// one result stream. Both sides use valid/ready: a beat transfers on the
// rising clock edge where valid and ready are both high; the source holds
// data stable while valid is high and ready is low, and ready never depends
// combinationally on valid.
interface neighbor_aggregator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*DATA_WIDTH-1:0]   in_data;
  logic                          in_is_centroid;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*DATA_WIDTH-1:0]   out_data;

  // Feature source / result sink side
  modport master (
    output in_valid, in_data, in_is_centroid, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Aggregator side
  modport slave (
    input  in_valid, in_data, in_is_centroid, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/neighbor_aggregator.sv
// Streaming neighbourhood reduction: takes one centroid beat followed by k
// neighbour beats, reduces each lane (max / saturated sum / mean), optionally
// subtracts the centroid, and emits one saturated result beat per group.
module neighbor_aggregator #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  parameter int K_WIDTH    = 7
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [K_WIDTH-1:0]   cfg_k,
  input  logic [1:0]           cfg_mode,
  input  logic [2:0]           cfg_shift,
  input  logic                 cfg_sub_centroid,
  neighbor_aggregator_if.slave bus,
  output logic [15:0]          group_count,
  output logic                 err,
  output logic [1:0]           dbg_state
);
  localparam int ACC_WIDTH = DATA_WIDTH + K_WIDTH;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH+2-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_CENT = 2'd0, ST_NEIGH = 2'd1, ST_EMIT = 2'd2} state_t;

  state_t state_q, state_d;

  logic                          ready_en_q;
  logic [K_WIDTH-1:0]            k_q;
  logic [1:0]                    mode_q;
  logic [2:0]                    shift_q;
  logic                          sub_q;
  logic [K_WIDTH-1:0]            cnt_q;
  logic signed [DATA_WIDTH-1:0]  cent_q  [LANES];
  logic signed [ACC_WIDTH-1:0]   acc_q   [LANES];
  logic signed [ACC_WIDTH-1:0]   acc_nxt [LANES];
  logic [LANES*DATA_WIDTH-1:0]   res_data;
  logic [LANES*DATA_WIDTH-1:0]   out_data_q;

  logic in_fire, out_fire, last_beat, sum_mode;

  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign last_beat = (cnt_q + K_WIDTH'(1)) == k_q;
  // Modes 01 and 10 accumulate; 00 and the unused 11 both reduce by max.
  assign sum_mode  = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign bus.out_data = out_data_q;

  // Final per-lane value: optional mean shift, optional centroid subtract at
  // one extra bit so it cannot wrap, then clamp to the signed element range.
  function automatic logic [DATA_WIDTH-1:0] reduce_out(
    input logic signed [ACC_WIDTH-1:0]  acc_v,
    input logic signed [DATA_WIDTH-1:0] cen_v,
    input logic [1:0]                   mode_v,
    input logic [2:0]                   shift_v,
    input logic                         sub_v
  );
    logic signed [ACC_WIDTH:0] r;
    if (mode_v == 2'b10) r = {acc_v[ACC_WIDTH-1], acc_v >>> shift_v};
    else                 r = {acc_v[ACC_WIDTH-1], acc_v};
    if (sub_v) r = r - {{(ACC_WIDTH+1-DATA_WIDTH){cen_v[DATA_WIDTH-1]}}, cen_v};
    if (r > SAT_MAX)      reduce_out = SAT_MAX[DATA_WIDTH-1:0];
    else if (r < SAT_MIN) reduce_out = SAT_MIN[DATA_WIDTH-1:0];
    else                  reduce_out = r[DATA_WIDTH-1:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_CENT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CENT:  if (in_fire && bus.in_is_centroid)
                  state_d = (cfg_k == '0) ? ST_EMIT : ST_NEIGH;
      ST_NEIGH: if (in_fire && last_beat) state_d = ST_EMIT;
      ST_EMIT:  if (out_fire) state_d = ST_CENT;
      default:  state_d = ST_CENT;
    endcase
  end

  // Handshake outputs and debug state decode
  always_comb begin
    bus.in_ready  = ready_en_q && (state_q != ST_EMIT);
    bus.out_valid = (state_q == ST_EMIT);
    dbg_state     = state_q;
  end

  // Per-lane accumulator update for the beat currently offered
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      logic signed [DATA_WIDTH-1:0] lane_in;
      logic signed [ACC_WIDTH-1:0]  ext;
      lane_in = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      ext     = {{K_WIDTH{lane_in[DATA_WIDTH-1]}}, lane_in};
      if (sum_mode)          acc_nxt[i] = acc_q[i] + ext;
      else if (cnt_q == '0)  acc_nxt[i] = ext;
      else                   acc_nxt[i] = (ext > acc_q[i]) ? ext : acc_q[i];
    end
  end

  // Result beat: k=0 groups reduce to zero against the incoming centroid and
  // live config; otherwise use the updated accumulators and frozen config.
  always_comb begin
    res_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (state_q == ST_CENT)
        res_data[i*DATA_WIDTH +: DATA_WIDTH] =
          reduce_out('0, bus.in_data[i*DATA_WIDTH +: DATA_WIDTH],
                     cfg_mode, cfg_shift, cfg_sub_centroid);
      else
        res_data[i*DATA_WIDTH +: DATA_WIDTH] =
          reduce_out(acc_nxt[i], cent_q[i], mode_q, shift_q, sub_q);
    end
  end

  // Datapath: config/centroid latch, accumulation, result capture, counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_en_q  <= 1'b0;
      k_q         <= '0;
      mode_q      <= '0;
      shift_q     <= '0;
      sub_q       <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      group_count <= '0;
      err         <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        cent_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      ready_en_q <= 1'b1;
      case (state_q)
        ST_CENT: if (in_fire) begin
          if (bus.in_is_centroid) begin
            k_q     <= cfg_k;
            mode_q  <= cfg_mode;
            shift_q <= cfg_shift;
            sub_q   <= cfg_sub_centroid;
            cnt_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
              cent_q[i] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
              acc_q[i]  <= '0;
            end
            if (cfg_k == '0) out_data_q <= res_data;
          end else begin
            err <= 1'b1;
          end
        end
        ST_NEIGH: if (in_fire) begin
          for (int i = 0; i < LANES; i++) acc_q[i] <= acc_nxt[i];
          cnt_q <= cnt_q + K_WIDTH'(1);
          if (bus.in_is_centroid) err <= 1'b1;
          if (last_beat) out_data_q <= res_data;
        end
        ST_EMIT: if (out_fire) group_count <= group_count + 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neighbor_aggregator.sv
// Directed bench for neighbor_aggregator: hand-computed vectors for each
// reduction mode, saturation, mean flooring, backpressure, k=0, error flag
// and mid-group reset.
module tb_neighbor_aggregator;
  localparam int DW = 8;
  localparam int LN = 16;
  localparam int KW = 7;

  logic          clk = 1'b0;
  logic          rstn;
  logic [KW-1:0] cfg_k;
  logic [1:0]    cfg_mode;
  logic [2:0]    cfg_shift;
  logic          cfg_sub_centroid;
  logic [15:0]   group_count;
  logic          err;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  int exp_gc   = 0;

  neighbor_aggregator_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

  neighbor_aggregator #(.DATA_WIDTH(DW), .LANES(LN), .K_WIDTH(KW)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .cfg_k            (cfg_k),
    .cfg_mode         (cfg_mode),
    .cfg_shift        (cfg_shift),
    .cfg_sub_centroid (cfg_sub_centroid),
    .bus              (bus),
    .group_count      (group_count),
    .err              (err),
    .dbg_state        (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] fill(input logic [7:0] v);
    logic [127:0] r;
    for (int i = 0; i < LN; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic set_cfg(input int k, input logic [1:0] mode, input logic [2:0] sh, input logic sub);
    cfg_k = KW'(k); cfg_mode = mode; cfg_shift = sh; cfg_sub_centroid = sub;
  endtask

  // Offer one beat and hold it until accepted (bounded)
  task automatic send_beat(input logic [127:0] d, input logic c);
    int waited = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_is_centroid = c;
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    check("in_ready_for_beat", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_is_centroid = 1'b0;
  endtask

  // Accept one result beat (bounded wait) and track expected group count
  task automatic take_result();
    int waited = 0;
    while (!bus.out_valid && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    check("out_valid_wait", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_gc++;
    check("group_count", group_count, 128'(exp_gc));
    check("in_ready_after_emit", bus.in_ready, 1'b1);
  endtask

  logic [127:0] d, e, held;

  initial begin
    rstn = 1'b0;
    set_cfg(0, 2'b00, 3'd0, 1'b0);
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_is_centroid = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_group_count", group_count, '0);
    check("rst_err", err, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    @(negedge clk) rstn = 1'b1;
    #1 check("release_in_ready_low", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    check("release_in_ready_high", bus.in_ready, 1'b1);

    // Max with subtract: lane0 max 20 - 10 = 10, others 1 - 10 = -9
    set_cfg(4, 2'b00, 3'd0, 1'b1);
    send_beat(fill(8'd10), 1'b1);
    d = fill(8'd1); d[7:0] = 8'd5;   send_beat(d, 1'b0);
    d[7:0] = 8'hFD;                  send_beat(d, 1'b0);
    d[7:0] = 8'd20;                  send_beat(d, 1'b0);
    d[7:0] = 8'd7;                   send_beat(d, 1'b0);
    e = fill(8'hF7); e[7:0] = 8'd10;
    check("max_sub_valid_latency", bus.out_valid, 1'b1);
    check("max_sub_in_ready", bus.in_ready, 1'b0);
    check("max_sub_data", bus.out_data, e);
    take_result();

    // Saturated sum, positive then negative
    set_cfg(8, 2'b01, 3'd0, 1'b0);
    send_beat(fill(8'd3), 1'b1);
    for (int i = 0; i < 8; i++) send_beat(fill(8'd100), 1'b0);
    check("sum_sat_pos", bus.out_data, fill(8'h7F));
    take_result();
    send_beat(fill(8'd3), 1'b1);
    for (int i = 0; i < 8; i++) send_beat(fill(8'h9C), 1'b0);
    check("sum_sat_neg", bus.out_data, fill(8'h80));
    take_result();

    // Mean with floor; config changes after the centroid must be ignored
    set_cfg(4, 2'b10, 3'd2, 1'b0);
    send_beat(fill(8'd50), 1'b1);
    set_cfg(1, 2'b00, 3'd0, 1'b1);
    d = '0; d[7:0] = 8'd1;  send_beat(d, 1'b0);
    d[7:0] = 8'd2;          send_beat(d, 1'b0);
    d[7:0] = 8'd3;          send_beat(d, 1'b0);
    d[7:0] = 8'hF9;         send_beat(d, 1'b0);
    e = '0; e[7:0] = 8'hFF;
    check("mean_floor_neg", bus.out_data, e);
    take_result();
    set_cfg(4, 2'b10, 3'd2, 1'b0);
    send_beat(fill(8'd50), 1'b1);
    for (int i = 0; i < 4; i++) send_beat(fill(8'd4), 1'b0);
    check("mean_exact", bus.out_data, fill(8'd4));
    take_result();

    // Backpressure: result held 5 cycles, then a single-cycle ready pulse
    set_cfg(2, 2'b00, 3'd0, 1'b0);
    send_beat(fill(8'd0), 1'b1);
    send_beat(fill(8'hFB), 1'b0);
    send_beat(fill(8'hEC), 1'b0);
    held = bus.out_data;
    check("bp_first_data", held, fill(8'hFB));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_out_data", bus.out_data, fill(8'hFB));
      check("bp_in_ready", bus.in_ready, 1'b0);
    end
    take_result();
    repeat (3) @(posedge clk);
    #1;
    check("bp_single_increment", group_count, 128'(exp_gc));
    check("bp_out_valid_cleared", bus.out_valid, 1'b0);

    // k=0 with subtract: 0 - 3 = -3, one clock after the centroid
    set_cfg(0, 2'b00, 3'd0, 1'b1);
    d = '0; d[7:0] = 8'd3;
    send_beat(d, 1'b1);
    e = '0; e[7:0] = 8'hFD;
    check("k0_valid_latency", bus.out_valid, 1'b1);
    check("k0_data", bus.out_data, e);
    take_result();

    // Mode 11 behaves as max
    set_cfg(4, 2'b11, 3'd0, 1'b1);
    send_beat(fill(8'd10), 1'b1);
    d = fill(8'd1); d[7:0] = 8'd5;   send_beat(d, 1'b0);
    d[7:0] = 8'hFD;                  send_beat(d, 1'b0);
    d[7:0] = 8'd20;                  send_beat(d, 1'b0);
    d[7:0] = 8'd7;                   send_beat(d, 1'b0);
    e = fill(8'hF7); e[7:0] = 8'd10;
    check("mode11_as_max", bus.out_data, e);
    take_result();

    // Neighbour-flagged beat in CENT is dropped and flags err
    check("err_clear_before", err, 1'b0);
    send_beat(fill(8'd99), 1'b0);
    check("err_cent_drop", err, 1'b1);
    check("err_cent_state", dbg_state, 2'd0);
    // Centroid-flagged beat inside the group counts as a neighbour
    set_cfg(2, 2'b01, 3'd0, 1'b0);
    send_beat(fill(8'd1), 1'b1);
    send_beat(fill(8'd3), 1'b0);
    check("err_neigh_state", dbg_state, 2'd1);
    send_beat(fill(8'd4), 1'b1);
    check("err_neigh_counted", bus.out_data, fill(8'd7));
    check("err_sticky", err, 1'b1);
    take_result();

    // Reset after 2 of 4 neighbours discards the partial group
    set_cfg(4, 2'b00, 3'd0, 1'b0);
    send_beat(fill(8'd0), 1'b1);
    send_beat(fill(8'd60), 1'b0);
    send_beat(fill(8'd70), 1'b0);
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_group_count", group_count, '0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    exp_gc = 0;
    @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    set_cfg(4, 2'b01, 3'd0, 1'b0);
    send_beat(fill(8'd0), 1'b1);
    send_beat(fill(8'd1), 1'b0);
    send_beat(fill(8'd2), 1'b0);
    send_beat(fill(8'd3), 1'b0);
    send_beat(fill(8'd4), 1'b0);
    check("midrst_next_group", bus.out_data, fill(8'd10));
    take_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/neighbor_aggregator.md
Name: neighbor_aggregator

Overview:
Parametrised streaming neighbourhood-reduction engine for the point-feature aggregation path. It generalises the fixed 16-channel, 32-bank max/subtract pair to configurable lane count, group size and reduction mode.
- Input: one centroid beat, then cfg_k neighbour beats.
- Per lane it reduces the neighbour beats (max, saturated sum or mean) and optionally subtracts the centroid feature.
- Output: one result beat per group, under valid/ready handshakes on both sides.
- It sits between PFT read-out and the global-buffer write path.

Parameters:
DATA_WIDTH, 8, signed feature element width
LANES, 16, feature channels per beat
K_WIDTH, 7, width of neighbour count (max group 2^K_WIDTH-1)
ACC_WIDTH (localparam), DATA_WIDTH+K_WIDTH, accumulator width; sum cannot overflow

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
cfg_k  in  K_WIDTH  neighbours per group
cfg_mode  in  2  00 max, 01 saturated sum, 10 mean, 11 treated as max
cfg_shift  in  3  mean divisor = 2^cfg_shift
cfg_sub_centroid  in  1  subtract centroid from reduced value
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_data  in  LANES*DATA_WIDTH  feature beat, lane i at [i*DATA_WIDTH+:DATA_WIDTH]
in_is_centroid  in  1  beat is the group centroid
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  LANES*DATA_WIDTH  result, same lane packing
group_count  out  16  groups emitted, wraps at 65535->0
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async assert, sync release):
  - State CENT; accumulators, centroid register and beat counter all 0.
  - out_valid=0, out_data=0, group_count=0, err=0.
  - in_ready=0 while rstn low, 1 from the first clock after release.
  - Reset mid-group discards the partial group completely.
- CENT state (in_ready=1):
  - On an accepted beat with in_is_centroid=1: latch in_data as centroid and latch cfg_k/mode/shift/sub. The config is frozen for the whole group.
  - If latched k=0, go to EMIT with a reduced value of 0. Otherwise clear the beat counter and go to NEIGH.
  - An accepted beat with in_is_centroid=0 is dropped, err<=1, state stays CENT.
- NEIGH state (in_ready=1):
  - Each accepted beat updates every lane.
  - Max: the first beat loads the lane, later beats keep the signed max.
  - Sum/mean: signed add into ACC_WIDTH.
  - A beat with in_is_centroid=1 is still consumed as a neighbour and sets err<=1.
  - On acceptance of beat number k, compute the result and go to EMIT.
- Result per lane:
  - r = acc for max/sum; r = acc >>> cfg_shift (arithmetic, floors toward -inf) for mean.
  - If sub enabled, r = r - centroid at ACC_WIDTH+1 bits.
  - Saturate to signed DATA_WIDTH: >max gives 2^(DW-1)-1, <min gives -2^(DW-1).
- EMIT state (in_ready=0):
  - out_valid=1 from the cycle after the last accepted neighbour (or after the centroid when k=0). That is a latency of 1 clock.
  - out_data is registered and held stable until out_valid&out_ready.
  - On the handshake: out_valid<=0, group_count+1, go to CENT. in_ready returns to 1 the next cycle.
- No bubble is needed inside a group: back-to-back neighbour beats are accepted every cycle.
- Config changes outside the centroid-accept cycle have no effect on the current group.
- err is cleared only by reset. It never blocks operation.

Test Plan:
- Max with subtract: k=4, mode 00, sub=1, centroid all lanes 10; lane0 neighbours 5,-3,20,7, other lanes all 1 -> out_valid one clock after the 4th beat; lane0=10, other lanes=-9.
- Sum saturation: k=8, mode 01, sub=0, all lanes +100 -> every lane 127; repeat with -100 -> every lane -128; group_count=2.
- Mean floor: k=4, mode 10, shift=2, lane0 neighbours 1,2,3,-7 (sum -1) -> lane0=-1; neighbours 4,4,4,4 -> lane0=4.
- Backpressure: out_ready held low 5 cycles after result -> out_valid stays 1, out_data constant, in_ready=0; a single out_ready pulse -> group_count increments exactly once.
- k=0 and mode 11: k=0, sub=1, centroid lane0=3 -> out lane0=-3 one clock after the centroid beat; mode 11 gives results identical to mode 00.
- Errors and reset:
  - Neighbour-flagged beat in CENT -> dropped, err=1.
  - Centroid-flagged beat in NEIGH -> counted as a neighbour, err=1.
  - rstn pulsed low after 2 of 4 neighbours -> out_valid=0, err=0, and the next full group yields the correct result.
